// File: rtl/lopd_norm_seq.sv
// rtl/lopd_norm_seq.sv - multi-cycle leading-one normalizer driving an external 16-bit LOPD
//
// Purpose:
//   Takes an unnormalized mantissa from the adder and scans it one 16-bit slice
//   per cycle, starting at the MSB slice. Each slice goes to an external LOPD.
//   The block then left-shifts the mantissa so its MSB is 1, and reports the
//   shift amount to the exponent adjust stage.
//
// Optional feature:
//   LOPD_NORM_BACK2BACK_EN - lets DONE hand off its result and accept the next
//   operand on the same edge, so there is no idle cycle between transactions.
//
// Ports:
//   i_clk, i_rst          clock; synchronous active-high reset
//   i_valid / o_ready     upstream handshake
//   i_data                unnormalized mantissa (DATA_W bits)
//   o_lopd_data           slice under scan, sent to the external LOPD (0 outside SCAN)
//   i_lopd_pos            LOPD leading-one index within the slice (15 = MSB)
//   i_lopd_zero           LOPD flag: the slice is all zero
//   o_valid / i_ready     downstream handshake
//   o_data                normalized mantissa
//   o_shift               left-shift amount that was applied
//   o_zero_flag           the operand was entirely zero
module lopd_norm_seq #(
  parameter  int DATA_W    = 48,
  localparam int NUM_SLICE = DATA_W / 16,
  localparam int SHIFT_W   = $clog2(DATA_W)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [DATA_W-1:0]  i_data,
  output logic [15:0]        o_lopd_data,
  input  logic [3:0]         i_lopd_pos,
  input  logic               i_lopd_zero,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [DATA_W-1:0]  o_data,
  output logic [SHIFT_W-1:0] o_shift,
  output logic               o_zero_flag
);

  // DATA_W = 16*NUM_SLICE, so SHIFT_W = 4 + clog2(NUM_SLICE). The slice index
  // therefore occupies exactly the upper SHIFT_W-4 bits of a shift amount.
  localparam int IDX_W = SHIFT_W - 4;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_SLICE - 1);

  if ((DATA_W % 16) != 0 || DATA_W < 32) begin : g_bad_width
    $error("lopd_norm_seq: DATA_W must be a multiple of 16 and at least 32");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state, next_state;
  logic [DATA_W-1:0]  r_data;
  logic [IDX_W-1:0]   r_idx;
  logic [SHIFT_W-1:0] r_shift;

  logic [DATA_W-1:0]  slice_aligned;
  logic [IDX_W-1:0]   lead_slices;
  logic [SHIFT_W-1:0] shift_calc;
  logic               accept;

  // The current slice is moved down to bits [15:0].
  assign slice_aligned = r_data >> {r_idx, 4'b0000};

  // Shift = 16*(zero slices above this one) + (15 - pos). For a 4-bit value,
  // 15 - pos is ~pos, and 16*lead_slices is a concatenation with four zero bits.
  assign lead_slices = IDX_TOP - r_idx;
  assign shift_calc  = {lead_slices, ~i_lopd_pos};

  always_comb begin
    next_state  = state;
    o_lopd_data = 16'h0000;
    o_valid     = 1'b0;
`ifdef LOPD_NORM_BACK2BACK_EN
    o_ready     = (state == IDLE) || ((state == DONE) && i_ready);
`else
    o_ready     = (state == IDLE);
`endif
    case (state)
      IDLE: begin
        if (i_valid) next_state = SCAN;
      end
      SCAN: begin
        o_lopd_data = slice_aligned[15:0];
        if (!i_lopd_zero)      next_state = SHIFT;
        else if (r_idx == '0)  next_state = DONE;
      end
      SHIFT: begin
        next_state = DONE;
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) begin
`ifdef LOPD_NORM_BACK2BACK_EN
          next_state = i_valid ? SCAN : IDLE;
`else
          next_state = IDLE;
`endif
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // o_ready is only high in IDLE or DONE, so a capture never collides with
  // the r_idx decrement that happens in SCAN.
  assign accept = i_valid && o_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      r_data      <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      o_data      <= '0;
      o_shift     <= '0;
      o_zero_flag <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        r_data <= i_data;
        r_idx  <= IDX_TOP;
      end
      case (state)
        SCAN: begin
          if (!i_lopd_zero) begin
            r_shift <= shift_calc;
          end else if (r_idx != '0) begin
            r_idx <= r_idx - 1'b1;
          end else begin
            o_data      <= '0;
            o_shift     <= '0;
            o_zero_flag <= 1'b1;
          end
        end
        SHIFT: begin
          o_data      <= r_data << r_shift;
          o_shift     <= r_shift;
          o_zero_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lopd_norm_seq.sv
// tb/tb_lopd_norm_seq.sv - self-checking bench for lopd_norm_seq
module tb_lopd_norm_seq;

  localparam int DATA_W    = 48;
  localparam int NUM_SLICE = DATA_W / 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [47:0] in_data;
  logic [15:0] lopd_data;
  logic [3:0]  lopd_pos;
  logic        lopd_zero;
  logic        out_valid;
  logic        in_ready;
  logic [47:0] out_data;
  logic [5:0]  out_shift;
  logic        out_zero;

  int checks = 0;
  int errors = 0;
  logic [15:0] seen [0:19];

  always #5 clk = ~clk;

  lopd_norm_seq #(.DATA_W(DATA_W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (in_valid),
    .o_ready     (out_ready),
    .i_data      (in_data),
    .o_lopd_data (lopd_data),
    .i_lopd_pos  (lopd_pos),
    .i_lopd_zero (lopd_zero),
    .o_valid     (out_valid),
    .i_ready     (in_ready),
    .o_data      (out_data),
    .o_shift     (out_shift),
    .o_zero_flag (out_zero)
  );

  // External leading-one detector
  always_comb begin
    lopd_zero = (lopd_data == 16'h0000);
    lopd_pos  = 4'd0;
    for (int b = 0; b < 16; b++)
      if (lopd_data[b]) lopd_pos = 4'(b);
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: count leading zeros of the whole word. Then the number of
  // scanned slices is lz/16+1, and the latency is that count plus 2.
  task automatic ref_model(input logic [47:0] d, output logic [47:0] od,
                           output logic [5:0] sh, output logic z, output int lat);
    int msb;
    msb = -1;
    for (int i = 0; i < DATA_W; i++) if (d[i]) msb = i;
    if (msb < 0) begin
      od = '0; sh = '0; z = 1'b1; lat = NUM_SLICE + 1;
    end else begin
      sh = 6'(DATA_W - 1 - msb);
      od = d << sh;
      z = 1'b0;
      lat = int'(sh) / 16 + 3;
    end
  endtask

  task automatic run_op(input string nm, input logic [47:0] d, input logic [47:0] e_data,
                        input logic [5:0] e_shift, input logic e_zero, input int e_lat,
                        input int hold);
    int edges;
    check({nm, ".ready_in"}, 64'(out_ready), 64'd1);
    in_ready = (hold == 0);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    in_valid = 1'b0;
    seen[0] = lopd_data;
    while (!out_valid && edges < 19) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      seen[edges-1] = lopd_data;
    end
    check({nm, ".latency"}, 64'(edges), 64'(e_lat));
    check({nm, ".data"}, 64'(out_data), 64'(e_data));
    check({nm, ".shift"}, 64'(out_shift), 64'(e_shift));
    check({nm, ".zero"}, 64'(out_zero), 64'(e_zero));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_data  = 48'hFFFF_FFFF_FFFF;
      check({nm, ".hold_ready"}, 64'(out_ready), 64'd0);
      @(posedge clk);
      @(negedge clk);
      check({nm, ".hold_valid"}, 64'(out_valid), 64'd1);
      check({nm, ".hold_data"}, 64'(out_data), 64'(e_data));
      check({nm, ".hold_shift"}, 64'(out_shift), 64'(e_shift));
      check({nm, ".hold_zero"}, 64'(out_zero), 64'(e_zero));
    end
    in_valid = 1'b0;
    in_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({nm, ".valid_drop"}, 64'(out_valid), 64'd0);
    check({nm, ".ready_back"}, 64'(out_ready), 64'd1);
  endtask

  typedef struct {
    logic [47:0] d;
    logic [47:0] e_data;
    logic [5:0]  e_shift;
    logic        e_zero;
    int          e_lat;
    int          hold;
  } vec_t;

  vec_t vecs [0:6];

  initial begin
    logic [47:0] rd, od;
    logic [5:0]  sh;
    logic        z;
    int          lat;
    bit          seen_valid;

    vecs[0] = '{48'h8000_0000_0000, 48'h8000_0000_0000, 6'd0,  1'b0, 3, 0};
    vecs[1] = '{48'h0000_0000_0001, 48'h8000_0000_0000, 6'd47, 1'b0, 5, 0};
    vecs[2] = '{48'h0000_0123_4567, 48'h91A2_B380_0000, 6'd23, 1'b0, 4, 0};
    vecs[3] = '{48'h0000_0000_0000, 48'h0000_0000_0000, 6'd0,  1'b1, 4, 0};
    vecs[4] = '{48'h8000_0000_0000, 48'h8000_0000_0000, 6'd0,  1'b0, 3, 10};
    vecs[5] = '{48'h0000_8000_0000, 48'h8000_0000_0000, 6'd16, 1'b0, 4, 0};
    vecs[6] = '{48'h0000_0000_8000, 48'h8000_0000_0000, 6'd32, 1'b0, 5, 2};

    rst = 1'b1; in_valid = 1'b0; in_ready = 1'b1; in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.data", 64'(out_data), 64'd0);
    check("rst.shift", 64'(out_shift), 64'd0);
    check("rst.zero", 64'(out_zero), 64'd0);
    check("rst.lopd", 64'(lopd_data), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst.ready", 64'(out_ready), 64'd1);

    for (int v = 0; v < 7; v++) begin
      run_op($sformatf("vec%0d", v), vecs[v].d, vecs[v].e_data, vecs[v].e_shift,
             vecs[v].e_zero, vecs[v].e_lat, vecs[v].hold);
      if (v == 1) begin
        check("vec1.lopd0", 64'(seen[0]), 64'h0000);
        check("vec1.lopd1", 64'(seen[1]), 64'h0000);
        check("vec1.lopd2", 64'(seen[2]), 64'h0001);
        check("vec1.lopd_shift", 64'(seen[3]), 64'h0000);
      end
      if (v == 2) check("vec2.lopd1", 64'(seen[1]), 64'h0123);
    end

    // Reset during the second SCAN cycle of a zero operand
    in_data = '0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst.ready", 64'(out_ready), 64'd1);
    check("midrst.data", 64'(out_data), 64'd0);
    check("midrst.shift", 64'(out_shift), 64'd0);
    check("midrst.zero", 64'(out_zero), 64'd0);
    check("midrst.lopd", 64'(lopd_data), 64'd0);
    seen_valid = out_valid;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    check("midrst.no_valid", 64'(seen_valid), 64'd0);

    for (int n = 0; n < 150; n++) begin
      rd = {16'($urandom), 32'($urandom)} >> $urandom_range(0, 48);
      ref_model(rd, od, sh, z, lat);
      run_op($sformatf("rnd%0d", n), rd, od, sh, z, lat, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
